// File: rtl/fire_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fire_sequencer: arm/charge/fire/dump sequencer for a capacitor igniter.  |
// | Optional macro ARM_TIMEOUT_EN adds a READY auto-disarm timeout. Rev 1.0  |
// +--------------------------------------------------------------------------+
module fire_sequencer #(
  parameter int unsigned DEBOUNCE_CYC  = 48000,
  parameter int unsigned CHARGE_TO_CYC = 240000000,
  parameter int unsigned FIRE_CYC      = 24000000,
  parameter int unsigned DUMP_CYC      = 4800000,
  parameter int unsigned PWM_PERIOD    = 1024,
  parameter int unsigned PWM_ON        = 64,
  parameter int unsigned ARM_TO_CYC    = 1440000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       arm_button,
  input  logic       fire_button,
  input  logic       cont,
  input  logic       lt3420_done,
  output logic       lt3420_charge,
  output logic       pwm,
  output logic       dump,
  output logic       arm_led,
  output logic       cont_led,
  output logic       speaker,
  output logic [2:0] state
);

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned MAX_DUR = umax(umax(CHARGE_TO_CYC, FIRE_CYC),
                                         umax(umax(DUMP_CYC, PWM_PERIOD), ARM_TO_CYC));
  localparam int CNT_W = $clog2(MAX_DUR + 1);
  localparam int DB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHARGE = 3'd1,
    S_READY  = 3'd2,
    S_FIRE   = 3'd3,
    S_DUMP   = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  state_t           cur, nxt;
  logic [CNT_W-1:0] cnt;
  logic [23:0]      tick;
  logic [3:0]       sync1, sync2;
  logic [1:0]       deb, deb_prev, press;
  logic             cont_s, done_s, arm_press, fire_press;
  logic             charge_d, pwm_d, dump_d, led_d, spk_d;

  // bit order: 0 arm, 1 fire, 2 cont, 3 done
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {lt3420_done, cont, fire_button, arm_button};
      sync2 <= sync1;
    end
  end

  assign cont_s   = sync2[2];
  assign done_s   = sync2[3];
  assign cont_led = cont_s;

  for (genvar i = 0; i < 2; i++) begin : g_debounce
    logic [DB_W-1:0] db_cnt;
    logic            level;
    // level follows the input only after DEBOUNCE_CYC consecutive differing samples
    always_ff @(posedge clk) begin
      if (reset) begin
        db_cnt <= '0;
        level  <= 1'b0;
      end else if (sync2[i] == level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_W'(DEBOUNCE_CYC - 1)) begin
        db_cnt <= '0;
        level  <= sync2[i];
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
    assign deb[i] = level;
  end

  always_ff @(posedge clk) begin
    if (reset) deb_prev <= '0;
    else       deb_prev <= deb;
  end

  assign press      = deb & ~deb_prev;
  assign arm_press  = press[0];
  assign fire_press = press[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      cur           <= S_IDLE;
      cnt           <= '0;
      tick          <= '0;
      lt3420_charge <= 1'b0;
      pwm           <= 1'b0;
      dump          <= 1'b0;
      arm_led       <= 1'b0;
      speaker       <= 1'b0;
    end else begin
      cur  <= nxt;
      tick <= tick + 24'd1;
      if (nxt != cur)    cnt <= '0;
      else if (cnt != '1) cnt <= cnt + 1'b1;
      lt3420_charge <= charge_d;
      pwm           <= pwm_d;
      dump          <= dump_d;
      arm_led       <= led_d;
      speaker       <= spk_d;
    end
  end

  always_comb begin
    nxt      = cur;
    charge_d = 1'b0;
    pwm_d    = 1'b0;
    dump_d   = 1'b0;
    led_d    = 1'b0;
    spk_d    = 1'b0;
    case (cur)
      S_IDLE: begin
        if (arm_press && cont_s) nxt = S_CHARGE;
      end
      S_CHARGE: begin
        charge_d = 1'b1;
        led_d    = tick[22];
        if (done_s)                                   nxt = S_READY;
        else if (arm_press || !cont_s)                nxt = S_DUMP;
        else if (cnt >= CNT_W'(CHARGE_TO_CYC - 1))    nxt = S_FAULT;
      end
      S_READY: begin
        led_d = 1'b1;
        spk_d = tick[14];
        // arm is checked before fire so a simultaneous press disarms
        if (arm_press || !cont_s) nxt = S_DUMP;
        else if (fire_press)      nxt = S_FIRE;
`ifdef ARM_TIMEOUT_EN
        else if (cnt >= CNT_W'(ARM_TO_CYC - 1)) nxt = S_DUMP;
`endif
      end
      S_FIRE: begin
        led_d = 1'b1;
        pwm_d = (cnt % CNT_W'(PWM_PERIOD)) < CNT_W'(PWM_ON);
        if (cnt >= CNT_W'(FIRE_CYC - 1)) nxt = S_DUMP;
      end
      S_DUMP: begin
        dump_d = 1'b1;
        if (cnt >= CNT_W'(DUMP_CYC - 1)) nxt = S_IDLE;
      end
      S_FAULT: begin
        dump_d = 1'b1;
        led_d  = tick[20];
        if (arm_press && !deb[1]) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  assign state = cur;

endmodule
`default_nettype wire

// File: tb/tb_fire_sequencer.sv
`default_nettype none
// Testbench for fire_sequencer: table-driven scenarios, reset corner cases and
// randomized stimulus, all checked every cycle against a behavioural model.
module tb_fire_sequencer;

  localparam int DEB   = 4;
  localparam int CHG   = 100;
  localparam int FIREN = 20;
  localparam int DUMPN = 10;
  localparam int PER   = 8;
  localparam int PON   = 2;
  localparam int ARMTO = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       arm_button = 1'b0, fire_button = 1'b0, cont = 1'b0, lt3420_done = 1'b0;
  logic       lt3420_charge, pwm, dump, arm_led, cont_led, speaker;
  logic [2:0] state;

  always #5 clk = ~clk;

  fire_sequencer #(
    .DEBOUNCE_CYC(DEB), .CHARGE_TO_CYC(CHG), .FIRE_CYC(FIREN), .DUMP_CYC(DUMPN),
    .PWM_PERIOD(PER), .PWM_ON(PON), .ARM_TO_CYC(ARMTO)
  ) dut (
    .clk(clk), .reset(reset), .arm_button(arm_button), .fire_button(fire_button),
    .cont(cont), .lt3420_done(lt3420_done), .lt3420_charge(lt3420_charge),
    .pwm(pwm), .dump(dump), .arm_led(arm_led), .cont_led(cont_led),
    .speaker(speaker), .state(state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model state: synchronizer stages, debounce windows, time spent in current state
  bit [3:0] m_s1, m_s2;
  bit       m_deb_arm, m_deb_fire, m_prev_arm, m_prev_fire;
  bit       q_arm[$], q_fire[$];
  int       m_st, m_age;
  bit [23:0] m_tick;
  bit       e_chg, e_pwm, e_dump, e_led, e_spk;

  function automatic bit window_level(input bit q[$], input bit cur_lvl);
    if (q.size() < DEB) return cur_lvl;
    foreach (q[i]) if (q[i] == cur_lvl) return cur_lvl;
    return !cur_lvl;
  endfunction

  task automatic model_step();
    bit arm_p, fire_p, c_s, d_s;
    int nst;
    if (reset) begin
      m_s1 = '0; m_s2 = '0;
      m_deb_arm = 0; m_deb_fire = 0; m_prev_arm = 0; m_prev_fire = 0;
      q_arm.delete(); q_fire.delete();
      m_st = 0; m_age = 1; m_tick = '0;
      {e_chg, e_pwm, e_dump, e_led, e_spk} = '0;
      return;
    end
    e_chg  = (m_st == 1);
    e_dump = (m_st == 4) || (m_st == 5);
    e_pwm  = (m_st == 3) && (((m_age - 1) % PER) < PON);
    e_led  = (m_st == 1) ? m_tick[22] : (m_st == 2 || m_st == 3) ? 1'b1 :
             (m_st == 5) ? m_tick[20] : 1'b0;
    e_spk  = (m_st == 2) && m_tick[14];

    arm_p  = m_deb_arm && !m_prev_arm;
    fire_p = m_deb_fire && !m_prev_fire;
    c_s    = m_s2[2];
    d_s    = m_s2[3];
    nst    = m_st;
    case (m_st)
      0: if (arm_p && c_s) nst = 1;
      1: if (d_s) nst = 2; else if (arm_p || !c_s) nst = 4; else if (m_age >= CHG) nst = 5;
      2: begin
        if (arm_p || !c_s) nst = 4;
        else if (fire_p) nst = 3;
`ifdef ARM_TIMEOUT_EN
        else if (m_age >= ARMTO) nst = 4;
`endif
      end
      3: if (m_age >= FIREN) nst = 4;
      4: if (m_age >= DUMPN) nst = 0;
      5: if (arm_p && !m_deb_fire) nst = 0;
      default: nst = 0;
    endcase
    m_age = (nst != m_st) ? 1 : m_age + 1;
    m_st  = nst;
    m_tick = m_tick + 24'd1;

    m_prev_arm  = m_deb_arm;
    m_prev_fire = m_deb_fire;
    q_arm.push_back(m_s2[0]);
    q_fire.push_back(m_s2[1]);
    if (q_arm.size() > DEB)  void'(q_arm.pop_front());
    if (q_fire.size() > DEB) void'(q_fire.pop_front());
    m_deb_arm  = window_level(q_arm, m_deb_arm);
    m_deb_fire = window_level(q_fire, m_deb_fire);

    m_s2 = m_s1;
    m_s1 = {lt3420_done, cont, fire_button, arm_button};
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    check("state",    32'(state),         32'(m_st));
    check("charge",   32'(lt3420_charge), 32'(e_chg));
    check("pwm",      32'(pwm),           32'(e_pwm));
    check("dump",     32'(dump),          32'(e_dump));
    check("arm_led",  32'(arm_led),       32'(e_led));
    check("speaker",  32'(speaker),       32'(e_spk));
    check("cont_led", 32'(cont_led),      32'(m_s2[2]));
    check("exclusive", 32'(32'(lt3420_charge) + 32'(pwm) + 32'(dump) <= 1), 32'd1);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  typedef struct {
    bit arm;
    bit fire;
    bit cnt;
    bit done;
    int n;
    int exp_st;
  } vec_t;

  vec_t tbl[$];

  initial begin
    tbl.push_back('{1, 0, 1, 0, 10, 1});   // arm press with continuity -> CHARGE
    tbl.push_back('{0, 0, 1, 0, 10, 1});
    tbl.push_back('{0, 0, 1, 1,  5, 2});   // charger done -> READY
    tbl.push_back('{0, 1, 1, 0, 10, 3});   // fire press -> FIRE
    tbl.push_back('{0, 0, 1, 0, 30, 0});   // FIRE 20 + DUMP 10 -> IDLE
    tbl.push_back('{1, 0, 0, 0, 10, 0});   // no continuity: stay IDLE
    tbl.push_back('{0, 0, 1, 0, 10, 0});
    tbl.push_back('{1, 0, 1, 0, 10, 1});
    tbl.push_back('{0, 0, 1, 0, 120, 5});  // charge timeout -> FAULT
    tbl.push_back('{1, 0, 1, 0, 10, 0});   // arm press, fire released -> IDLE
    tbl.push_back('{0, 0, 1, 0, 10, 0});
    tbl.push_back('{1, 0, 1, 0, 10, 1});
    tbl.push_back('{0, 0, 1, 1, 10, 2});
    tbl.push_back('{1, 1, 1, 0, 10, 4});   // simultaneous arm+fire -> DUMP
    tbl.push_back('{0, 0, 1, 0, 20, 0});
    tbl.push_back('{1, 0, 1, 0, 10, 1});
    tbl.push_back('{0, 0, 1, 1, 10, 2});
    tbl.push_back('{0, 1, 1, 0,  3, 2});   // 3-cycle fire glitch
    tbl.push_back('{0, 0, 1, 0, 10, 2});
    tbl.push_back('{0, 0, 0, 0,  3, 4});   // continuity loss -> DUMP in 3 cycles
    tbl.push_back('{0, 0, 1, 0, 20, 0});
    tbl.push_back('{1, 0, 1, 0, 10, 1});
    tbl.push_back('{0, 0, 1, 1, 10, 2});
`ifdef ARM_TIMEOUT_EN
    tbl.push_back('{0, 0, 1, 0, 60, 0});   // READY times out -> DUMP -> IDLE
    tbl.push_back('{0, 0, 0, 0,  5, 0});
`else
    tbl.push_back('{0, 0, 1, 0, 60, 2});   // READY held indefinitely
    tbl.push_back('{0, 0, 0, 0,  5, 4});
`endif
    tbl.push_back('{0, 0, 1, 0, 20, 0});

    reset = 1'b1;
    repeat (3) cyc();
    reset = 1'b0;

    foreach (tbl[i]) begin
      arm_button  = tbl[i].arm;
      fire_button = tbl[i].fire;
      cont        = tbl[i].cnt;
      lt3420_done = tbl[i].done;
      repeat (tbl[i].n) cyc();
      check($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].exp_st));
    end

    // reset in the middle of FIRE
    arm_button = 1; repeat (10) cyc();
    arm_button = 0; lt3420_done = 1; repeat (10) cyc();
    lt3420_done = 0; fire_button = 1; repeat (7) cyc();
    check("fire_entry", 32'(state), 32'd3);
    cyc();
    check("pwm_first", 32'(pwm), 32'd1);
    fire_button = 0;
    repeat (4) cyc();
    reset = 1; cyc(); reset = 0;
    check("rst_fire_state", 32'(state), 32'd0);
    check("rst_fire_pwm",   32'(pwm),   32'd0);
    check("rst_fire_dump",  32'(dump),  32'd0);

    // reset in the middle of CHARGE
    repeat (5) cyc();
    arm_button = 1; repeat (8) cyc();
    check("chg_on", 32'(lt3420_charge), 32'd1);
    arm_button = 0;
    reset = 1; cyc(); reset = 0;
    check("rst_chg_charge", 32'(lt3420_charge), 32'd0);
    check("rst_chg_state",  32'(state),         32'd0);

    // randomized segments with varying hold lengths to produce glitches and presses
    for (int t = 0; t < 20000; ) begin
      int len;
      len         = int'($urandom_range(12, 1));
      arm_button  = ($urandom_range(99, 0) < 30);
      fire_button = ($urandom_range(99, 0) < 30);
      cont        = ($urandom_range(99, 0) < 92);
      lt3420_done = ($urandom_range(99, 0) < 20);
      repeat (len) cyc();
      t += len;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
